// File: rtl/onehot_sel_seq_pkg.sv
// ============================================================================
// Module      : onehot_sel_seq_pkg
// Description : Shared mode encoding and FSM state type for onehot_sel_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package onehot_sel_seq_pkg;

  // Operating mode encoding driven on the mode port
  localparam logic [1:0] MODE_DECODE    = 2'b00;
  localparam logic [1:0] MODE_SCAN_UP   = 2'b01;
  localparam logic [1:0] MODE_SCAN_DOWN = 2'b10;
  localparam logic [1:0] MODE_HOLD      = 2'b11;

  // IDLE: output cleared; ACTIVE: output carries exactly one set bit
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

endpackage : onehot_sel_seq_pkg

`default_nettype wire

// File: rtl/onehot_sel_seq_dec.sv
// ============================================================================
// Module      : onehot_dec
// Description : Combinational SEL_W-to-2^SEL_W binary to one-hot decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module onehot_dec #(
  parameter int SEL_W = 2
) (
  input  logic [SEL_W-1:0]      i_sel,
  output logic [(1<<SEL_W)-1:0] o_onehot
);

  localparam int c_N = 1 << SEL_W;

  // One comparator per output bit
  for (genvar gi = 0; gi < c_N; gi++) begin : g_bit
    assign o_onehot[gi] = (i_sel == SEL_W'(gi));
  end

endmodule : onehot_dec

`default_nettype wire

// File: rtl/onehot_sel_seq.sv
// ============================================================================
// Module      : onehot_sel_seq
// Description : Registered one-hot selector with decode, prescaled up/down
//               rotating scan, hold and wrap pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module onehot_sel_seq
  import onehot_sel_seq_pkg::*;
#(
  parameter int SEL_W = 2,
  parameter int DIV   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   load,
  output logic [(1<<SEL_W)-1:0]  O,
  output logic                   valid,
  output logic                   wrap
);

  localparam int c_N  = 1 << SEL_W;
  // Prescaler is ceil(log2(DIV)) bits, never narrower than one bit
  localparam int c_PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(DIV - 1);
  localparam logic [c_PW-1:0] c_PRESC_ONE = c_PW'(1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [c_N-1:0]  r_o;
  logic [c_N-1:0]  w_o_nxt;
  logic [c_PW-1:0] r_presc;
  logic [c_PW-1:0] w_presc_nxt;
  logic [c_PW-1:0] w_presc_eff;
  logic            r_wrap;
  logic            w_wrap_nxt;
  logic [1:0]      r_mode;
  logic [1:0]      w_mode_nxt;

  logic [c_N-1:0]  w_dec;
  logic [c_N-1:0]  w_rotl;
  logic [c_N-1:0]  w_rotr;

  onehot_dec #(
    .SEL_W (SEL_W)
  ) u_dec (
    .i_sel    (sel),
    .o_onehot (w_dec)
  );

  // Neighbouring scan positions; N is at least 2 so the slices are legal
  assign w_rotl = {r_o[c_N-2:0], r_o[c_N-1]};
  assign w_rotr = {r_o[0], r_o[c_N-1:1]};

  // State, output and prescaler registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_o     <= '0;
      r_presc <= '0;
      r_wrap  <= 1'b0;
      r_mode  <= MODE_DECODE;
    end else begin
      r_state <= w_state_nxt;
      r_o     <= w_o_nxt;
      r_presc <= w_presc_nxt;
      r_wrap  <= w_wrap_nxt;
      r_mode  <= w_mode_nxt;
    end
  end

  // Next-state logic: decode/load/step selection, prescaler and wrap detect
  always_comb begin
    w_state_nxt = r_state;
    w_o_nxt     = r_o;
    w_presc_nxt = r_presc;
    w_presc_eff = r_presc;
    w_wrap_nxt  = 1'b0;
    w_mode_nxt  = r_mode;
    if (en) begin
      w_mode_nxt = mode;
      // A newly sampled mode starts counting from zero on this very edge
      w_presc_eff = (mode != r_mode) ? '0 : r_presc;
      w_presc_nxt = w_presc_eff;
      case (mode)
        MODE_DECODE: begin
          w_state_nxt = ST_ACTIVE;
          w_o_nxt     = w_dec;
          w_presc_nxt = '0;
        end
        MODE_SCAN_UP, MODE_SCAN_DOWN: begin
          if (load) begin
            w_state_nxt = ST_ACTIVE;
            w_o_nxt     = w_dec;
            w_presc_nxt = '0;
          end else if (r_state == ST_ACTIVE) begin
            if (w_presc_eff == c_PRESC_MAX) begin
              w_presc_nxt = '0;
              if (mode == MODE_SCAN_UP) begin
                w_o_nxt    = w_rotl;
                w_wrap_nxt = r_o[c_N-1];
              end else begin
                w_o_nxt    = w_rotr;
                w_wrap_nxt = r_o[0];
              end
            end else begin
              w_presc_nxt = w_presc_eff + c_PRESC_ONE;
            end
          end
        end
        default: begin
          // HOLD: everything keeps its value, load ignored
        end
      endcase
    end
  end

  assign O     = r_o;
  assign valid = (r_state == ST_ACTIVE);
  assign wrap  = r_wrap;

endmodule : onehot_sel_seq

`default_nettype wire

// File: tb/tb_onehot_sel_seq.sv
// ============================================================================
// Module      : tb_onehot_sel_seq
// Description : Self-checking bench for onehot_sel_seq, two configurations
//               (SEL_W=2/DIV=1 and SEL_W=3/DIV=3) against a position model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_onehot_sel_seq;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic [1:0] sel_a;
  logic [2:0] sel_b;
  logic       load;
  logic [3:0] o_a;
  logic [7:0] o_b;
  logic       valid_a, valid_b, wrap_a, wrap_b;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [7:0] oa;
    logic       va;
    logic       wa;
    logic [7:0] ob;
    logic       vb;
    logic       wb;
  } exp_t;

  exp_t sb_q[$];

  // Reference model: scan position as an index (-1 means idle)
  int m_n[2] = '{4, 8};
  int m_d[2] = '{1, 3};
  int m_pos[2];
  int m_cnt[2];
  int m_last[2];
  bit m_wrap[2];

  onehot_sel_seq #(.SEL_W(2), .DIV(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel_a),
    .load(load), .O(o_a), .valid(valid_a), .wrap(wrap_a)
  );

  onehot_sel_seq #(.SEL_W(3), .DIV(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel_b),
    .load(load), .O(o_b), .valid(valid_b), .wrap(wrap_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pos[k]  = -1;
      m_cnt[k]  = 0;
      m_last[k] = 0;
      m_wrap[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k, input bit e, input logic [1:0] m, input int s, input bit l);
    m_wrap[k] = 1'b0;
    if (!e) return;
    if (int'(m) != m_last[k]) m_cnt[k] = 0;
    m_last[k] = int'(m);
    if (m == 2'b00) begin
      m_pos[k] = s % m_n[k];
      m_cnt[k] = 0;
    end else if (m == 2'b01 || m == 2'b10) begin
      if (l) begin
        m_pos[k] = s % m_n[k];
        m_cnt[k] = 0;
      end else if (m_pos[k] >= 0) begin
        if (m_cnt[k] == m_d[k] - 1) begin
          m_cnt[k] = 0;
          if (m == 2'b01) begin
            m_wrap[k] = (m_pos[k] == m_n[k] - 1);
            m_pos[k]  = (m_pos[k] + 1) % m_n[k];
          end else begin
            m_wrap[k] = (m_pos[k] == 0);
            m_pos[k]  = (m_pos[k] + m_n[k] - 1) % m_n[k];
          end
        end else begin
          m_cnt[k]++;
        end
      end
    end
  endtask

  function automatic logic [7:0] pos2oh(input int p);
    logic [7:0] v;
    v = '0;
    if (p >= 0) v[p] = 1'b1;
    return v;
  endfunction

  // One enabled/disabled clock cycle: drive, predict, then compare after edge
  task automatic cyc(input bit e, input logic [1:0] m, input int s, input bit l);
    exp_t x;
    @(negedge clk);
    en    = e;
    mode  = m;
    sel_a = s[1:0];
    sel_b = s[2:0];
    load  = l;
    for (int k = 0; k < 2; k++) model_step(k, e, m, s, l);
    x.oa = pos2oh(m_pos[0]);
    x.va = (m_pos[0] >= 0);
    x.wa = m_wrap[0];
    x.ob = pos2oh(m_pos[1]);
    x.vb = (m_pos[1] >= 0);
    x.wb = m_wrap[1];
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    check_eq("O_a",     {28'd0, o_a},     {24'd0, x.oa});
    check_eq("valid_a", {31'd0, valid_a}, {31'd0, x.va});
    check_eq("wrap_a",  {31'd0, wrap_a},  {31'd0, x.wa});
    check_eq("O_b",     {24'd0, o_b},     {24'd0, x.ob});
    check_eq("valid_b", {31'd0, valid_b}, {31'd0, x.vb});
    check_eq("wrap_b",  {31'd0, wrap_b},  {31'd0, x.wb});
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    mode  = 2'b00;
    sel_a = '0;
    sel_b = '0;
    load  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_O_a", {28'd0, o_a}, 32'd0);
    check_eq("rst_valid_a", {31'd0, valid_a}, 32'd0);
    check_eq("rst_wrap_b", {31'd0, wrap_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with enable low
    repeat (5) cyc(1'b0, 2'b00, 3, 1'b0);

    // Decode sweep
    for (int i = 0; i < 4; i++) cyc(1'b1, 2'b00, i, 1'b0);
    check_eq("dec3_O_a", {28'd0, o_a}, 32'h8);

    // Scan up from 2, one step per cycle on config A
    cyc(1'b1, 2'b01, 2, 1'b1);
    check_eq("up_load_O_a", {28'd0, o_a}, 32'h4);
    cyc(1'b1, 2'b01, 0, 1'b0);
    cyc(1'b1, 2'b01, 0, 1'b0);
    check_eq("up_wrap_O_a", {28'd0, o_a}, 32'h1);
    check_eq("up_wrap_a", {31'd0, wrap_a}, 32'd1);
    cyc(1'b1, 2'b01, 0, 1'b0);
    check_eq("up_after_O_a", {28'd0, o_a}, 32'h2);

    // Scan down from 0 with DIV=3 on config B
    cyc(1'b1, 2'b10, 0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 2'b10, 0, 1'b0);
      if (i == 2) begin
        check_eq("dn_wrap_O_b", {24'd0, o_b}, 32'h80);
        check_eq("dn_wrap_b", {31'd0, wrap_b}, 32'd1);
      end
    end

    // Enable gaps, HOLD, and load colliding with a step
    cyc(1'b1, 2'b01, 1, 1'b1);
    cyc(1'b0, 2'b01, 0, 1'b0);
    cyc(1'b1, 2'b01, 0, 1'b0);
    cyc(1'b0, 2'b01, 0, 1'b0);
    cyc(1'b1, 2'b11, 6, 1'b1);
    cyc(1'b1, 2'b11, 0, 1'b0);
    cyc(1'b1, 2'b01, 0, 1'b0);
    cyc(1'b1, 2'b01, 0, 1'b0);
    cyc(1'b1, 2'b01, 5, 1'b1);
    check_eq("load_wins_O_a", {28'd0, o_a}, 32'h2);

    // Asynchronous reset in the middle of a scan
    cyc(1'b1, 2'b01, 0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_O_a", {28'd0, o_a}, 32'd0);
    check_eq("async_O_b", {24'd0, o_b}, 32'd0);
    check_eq("async_valid_b", {31'd0, valid_b}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Scan without load stays idle, then a single load activates
    repeat (10) cyc(1'b1, 2'b01, 3, 1'b0);
    cyc(1'b1, 2'b01, 1, 1'b1);
    check_eq("reload_O_a", {28'd0, o_a}, 32'h2);
    check_eq("reload_valid_a", {31'd0, valid_a}, 32'd1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
          int'($urandom_range(0, 7)), ($urandom_range(0, 5) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_onehot_sel_seq

`default_nettype wire

// File: doc/onehot_sel_seq.md
ONEHOT_SEL_SEQ -- requirements
Module: onehot_sel_seq

Interface
REQ-001 The block SHALL have parameter SEL_W, default 2, meaning the select width; output width is N = 2^SEL_W; legal range is 1..5.
REQ-002 The block SHALL have parameter DIV, default 1, meaning enabled cycles per scan step; legal range is 1..256.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 The block SHALL have port clk  in  1  system clock, rising-edge active.
REQ-005 The block SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 The block SHALL have port en  in  1  cycle enable; when low, all state holds.
REQ-007 The block SHALL have port mode  in  2  operating mode: 00 DECODE, 01 SCAN_UP, 10 SCAN_DOWN, 11 HOLD.
REQ-008 The block SHALL have port sel  in  SEL_W  binary select or scan seed.
REQ-009 The block SHALL have port load  in  1  seeds the scan position from sel.
REQ-010 The block SHALL have port O  out  N  registered one-hot output.
REQ-011 The block SHALL have port valid  out  1  high when O holds a decoded or scanned value.
REQ-012 The block SHALL have port wrap  out  1  one-cycle pulse on scan wrap-around.

Function
REQ-013 The block SHALL implement a two-state FSM: IDLE (O=0, valid=0) and ACTIVE (O one-hot, valid=1).
REQ-014 In IDLE, the block SHALL go to ACTIVE when en=1 and (mode=DECODE or load=1); O SHALL become onehot(sel) on that edge.
REQ-015 In IDLE, the block SHALL stay in IDLE when mode is SCAN_UP, SCAN_DOWN or HOLD and load=0.
REQ-016 In DECODE with en=1, O SHALL equal onehot(sel) one clock after sel is sampled, with latency exactly 1 cycle.
REQ-017 In SCAN_UP or SCAN_DOWN with en=1 and load=1, O SHALL load onehot(sel), and the prescaler SHALL clear to 0.
REQ-018 In SCAN_UP or SCAN_DOWN with en=1 and load=0, the prescaler SHALL increment; when it reaches DIV-1, it SHALL clear and O SHALL rotate.
REQ-019 In SCAN_UP, the rotation SHALL be left by 1 (bit i moves to bit i+1).
REQ-020 In SCAN_DOWN, the rotation SHALL be right by 1.
REQ-021 When a SCAN_UP step moves bit N-1 to bit 0, or a SCAN_DOWN step moves bit 0 to bit N-1, wrap SHALL be 1 for exactly the cycle after that edge; otherwise wrap SHALL be 0.
REQ-022 In HOLD, or when en=0, O, valid, the FSM state and the prescaler SHALL hold, and wrap SHALL be 0.
REQ-023 A mode change SHALL clear the prescaler; the new mode SHALL act on the first edge at which it is sampled.
REQ-024 With DIV=1, the block SHALL step on every enabled cycle.
REQ-025 load has priority over a scan step in the same cycle; load SHALL be ignored in DECODE and in HOLD.
REQ-026 O SHALL never have more than one bit set; in ACTIVE, O SHALL have exactly one bit set.
REQ-027 The prescaler SHALL be ceil(log2(DIV)) bits wide, minimum 1 bit; it SHALL never exceed DIV-1.

Reset
REQ-028 When rst_n=0, the block SHALL go immediately (asynchronously) to IDLE and set O=0, valid=0, wrap=0 and prescaler=0.
REQ-029 Reset in the middle of a scan SHALL discard the scan position; after release, the block SHALL require a DECODE or load to become ACTIVE again.
REQ-030 The first state change after reset SHALL occur on the first rising clk edge after rst_n goes high.

Structure
REQ-031 A shared package SHALL hold the mode encoding constants (MODE_DECODE, MODE_SCAN_UP, MODE_SCAN_DOWN, MODE_HOLD) and the FSM state encoding.
REQ-032 The block SHALL have one sub-module, onehot_dec: a combinational SEL_W-to-N decoder parametrised by SEL_W; when SEL_W=2, its outputs are 0001, 0010, 0100, 1000 for sel 0..3.
REQ-033 The rotate, prescaler and FSM logic SHALL reside in onehot_sel_seq.

Verification
REQ-034 Reset, then hold en=0 for 5 cycles -> O=0000, valid=0 and wrap=0 throughout; pulse rst_n low mid-scan -> O=0 at once, without waiting for a clock edge.
REQ-035 SEL_W=2, DECODE, en=1, sel=0,1,2,3 on successive cycles -> O=0001, 0010, 0100, 1000, each one cycle later; valid=1 from the first edge.
REQ-036 SEL_W=2, DIV=1, SCAN_UP, load with sel=2, then 3 steps -> O=0100, 1000, 0001 (wrap=1 in this cycle only), 0010.
REQ-037 SEL_W=3, DIV=3, SCAN_DOWN, load with sel=0, then 6 enabled cycles -> O=00000001 for 3 cycles, then 10000000 with wrap=1, then held for 3 cycles.
REQ-038 Scan with en toggling and HOLD inserted -> no step, no prescaler advance and no wrap while en=0 or mode=HOLD; load and step in the same cycle -> the load wins.
REQ-039 After reset, select SCAN_UP with load=0 for 10 cycles -> the block stays in IDLE with O=0; a single load with sel=1 -> O=0010 and valid=1.
